// File: rtl/aurva_lane_dispatch.sv
// Round-robin lane dispatcher/collector between an input and an output AXI stream.
// Words go out to lanes 0..N-1 in turn and results are gathered back in the same order.
module aurva_lane_dispatch #(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 256,
  parameter int unsigned C_NUM_LANES        = 4,
  parameter int unsigned C_MAX_INFLIGHT     = 32,
  parameter int unsigned C_XFER_SIZE_WIDTH  = 32
) (
  input  logic                                        aclk,
  input  logic                                        areset,
  input  logic                                        ctrl_start,
  input  logic [C_XFER_SIZE_WIDTH-1:0]                ctrl_word_count,
  output logic                                        ctrl_done,
  output logic                                        err_tlast,
  input  logic                                        s_axis_tvalid,
  output logic                                        s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]               s_axis_tdata,
  input  logic                                        s_axis_tlast,
  output logic [C_NUM_LANES-1:0]                      lane_tvalid,
  input  logic [C_NUM_LANES-1:0]                      lane_tready,
  output logic [C_NUM_LANES*C_AXIS_TDATA_WIDTH-1:0]   lane_tdata,
  input  logic [C_NUM_LANES-1:0]                      res_tvalid,
  output logic [C_NUM_LANES-1:0]                      res_tready,
  input  logic [C_NUM_LANES*C_AXIS_TDATA_WIDTH-1:0]   res_tdata,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]               m_axis_tdata,
  output logic                                        m_axis_tlast
);

  localparam int unsigned W    = C_AXIS_TDATA_WIDTH;
  localparam int unsigned XW   = C_XFER_SIZE_WIDTH;
  localparam int unsigned PtrW = $clog2(C_NUM_LANES);
  localparam logic [XW-1:0] MaxInflight = XW'(C_MAX_INFLIGHT);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   count_q, count_d;
  logic [XW-1:0]   disp_q, disp_d;
  logic [XW-1:0]   coll_q, coll_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            err_q, err_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [W-1:0]    out_data_q, out_data_d;

  logic [XW-1:0]   inflight;
  logic [XW-1:0]   count_m1;
  logic            run;
  logic            can_disp;
  logic            can_coll;
  logic            out_free;
  logic            disp_hs;
  logic            coll_hs;
  logic [W-1:0]    res_sel;

  assign run      = (state_q == StRun);
  assign inflight = disp_q - coll_q;
  assign count_m1 = count_q - XW'(1);
  assign out_free = !out_valid_q || m_axis_tready;
  assign can_disp = run && (disp_q < count_q) && (inflight < MaxInflight);
  assign can_coll = run && (coll_q < count_q) && out_free;

  assign s_axis_tready = can_disp && lane_tready[wr_ptr_q];
  assign disp_hs       = s_axis_tvalid && s_axis_tready;
  assign coll_hs       = can_coll && res_tvalid[rd_ptr_q];

  // Every lane sees the input word; only the selected lane gets tvalid.
  assign lane_tdata = {C_NUM_LANES{s_axis_tdata}};

  always_comb begin
    lane_tvalid           = '0;
    res_tready            = '0;
    lane_tvalid[wr_ptr_q] = can_disp && s_axis_tvalid;
    res_tready[rd_ptr_q]  = can_coll;
  end

  always_comb begin
    res_sel = '0;
    for (int unsigned i = 0; i < C_NUM_LANES; i++) begin
      if (rd_ptr_q == PtrW'(i)) res_sel = res_tdata[i*W +: W];
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    disp_d      = disp_q;
    coll_d      = coll_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      StIdle: begin
        if (ctrl_start) begin
          if (ctrl_word_count != '0) begin
            state_d  = StRun;
            count_d  = ctrl_word_count;
            err_d    = 1'b0;
            disp_d   = '0;
            coll_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (disp_hs) begin
          wr_ptr_d = wr_ptr_q + PtrW'(1);
          disp_d   = disp_q + XW'(1);
          if (s_axis_tlast != (disp_q == count_m1)) err_d = 1'b1;
        end
        if (coll_hs) begin
          rd_ptr_d = rd_ptr_q + PtrW'(1);
          coll_d   = coll_q + XW'(1);
        end
        if ((coll_q == count_q) && out_free) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (coll_hs) begin
      out_valid_d = 1'b1;
      out_last_d  = (coll_q == count_m1);
      out_data_d  = res_sel;
    end else if (out_valid_q && m_axis_tready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      disp_q      <= '0;
      coll_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      disp_q      <= disp_d;
      coll_q      <= coll_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign ctrl_done     = (state_q == StDone);
  assign err_tlast     = err_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tdata  = out_data_q;

endmodule
